bcd_stopwatch: RTL and testbench

//  Six-digit BCD stopwatch (MM:SS.cc) feeding the per-digit hex seven-segment decoders.
//  - Produces one 4-bit BCD nibble per display; each nibble drives one decoder's 4-bit input.
//  - Controlled by start/stop, clear and lap buttons.
//  - Counts in 10 ms ticks derived from the system clock.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_stopwatch.sv | 158 +++++++++++++++
 tb/tb_bcd_stopwatch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit width and per-digit maxima.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Digit order is dig0 (centiseconds units) .. dig5 (minutes tens).
    localparam logic [BCD_W-1:0] DIG_MAX [0:5] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5};

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with wrap at MAX and a combinational carry-out for rippling.
// Latency: q updates on the edge where inc is high; carry is combinational.
// Backpressure: none; inc is a single-cycle strobe.
import stopwatch_pkg::*;

module bcd_digit #(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] cnt;

    // Any value at or above MAX (including upset values) returns to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt >= MAX) ? '0 : cnt + 4'd1;
        end
    end

    assign q     = cnt;
    assign carry = inc && (cnt == MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS.cc BCD stopwatch with start/stop, clear and optional lap hold (macro LAP_HOLD_EN).
// Latency: button acts 3 edges after raw rise; digits update on the tick edge.
// Backpressure: none; button edges are one-cycle strobes, outputs always valid.
import stopwatch_pkg::*;

module bcd_stopwatch #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    output logic [BCD_W-1:0] dig0,
    output logic [BCD_W-1:0] dig1,
    output logic [BCD_W-1:0] dig2,
    output logic [BCD_W-1:0] dig3,
    output logic [BCD_W-1:0] dig4,
    output logic [BCD_W-1:0] dig5,
    output logic             running,
    output logic             wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [2:0]       ss_sync, clr_sync;
    logic             ss_edge, clr_edge;
    state_t           state, state_nxt;
    logic             do_clr;
    logic [PW-1:0]    pre;
    logic             tick;
    logic [BCD_W-1:0] q    [6];
    logic [BCD_W-1:0] disp [6];
    logic [5:0]       cy;

    // Two sync stages plus one history stage for rising-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync  <= '0;
            clr_sync <= '0;
        end else begin
            ss_sync  <= {ss_sync[1:0], start_stop};
            clr_sync <= {clr_sync[1:0], clear};
        end
    end

    assign ss_edge  = ss_sync[1]  & ~ss_sync[2];
    assign clr_edge = clr_sync[1] & ~clr_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Clear outranks start outside RUN; inside RUN clear is ignored.
    always_comb begin
        state_nxt = state;
        do_clr    = 1'b0;
        case (state)
            IDLE, PAUSE: begin
                if (clr_edge) begin
                    state_nxt = IDLE;
                    do_clr    = 1'b1;
                end else if (ss_edge) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ss_edge) state_nxt = PAUSE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tick = (state == RUN) && (pre == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (do_clr) begin
            pre <= '0;
        end else if (state == RUN) begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    bcd_digit #(.MAX(DIG_MAX[0])) u_d0 (.clk(clk), .rst(rst), .inc(tick),  .clr(do_clr), .q(q[0]), .carry(cy[0]));
    bcd_digit #(.MAX(DIG_MAX[1])) u_d1 (.clk(clk), .rst(rst), .inc(cy[0]), .clr(do_clr), .q(q[1]), .carry(cy[1]));
    bcd_digit #(.MAX(DIG_MAX[2])) u_d2 (.clk(clk), .rst(rst), .inc(cy[1]), .clr(do_clr), .q(q[2]), .carry(cy[2]));
    bcd_digit #(.MAX(DIG_MAX[3])) u_d3 (.clk(clk), .rst(rst), .inc(cy[2]), .clr(do_clr), .q(q[3]), .carry(cy[3]));
    bcd_digit #(.MAX(DIG_MAX[4])) u_d4 (.clk(clk), .rst(rst), .inc(cy[3]), .clr(do_clr), .q(q[4]), .carry(cy[4]));
    bcd_digit #(.MAX(DIG_MAX[5])) u_d5 (.clk(clk), .rst(rst), .inc(cy[4]), .clr(do_clr), .q(q[5]), .carry(cy[5]));

    // Carry out of the top digit only happens on the full 59:59.99 roll-over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= cy[5];
        end
    end

`ifdef LAP_HOLD_EN
    logic [2:0]       lap_sync;
    logic             lap_edge;
    logic             hold;
    logic [BCD_W-1:0] snap [6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_sync <= '0;
        end else begin
            lap_sync <= {lap_sync[1:0], lap};
        end
    end

    assign lap_edge = lap_sync[1] & ~lap_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= 1'b0;
            snap <= '{default: '0};
        end else if (state_nxt == IDLE) begin
            hold <= 1'b0;
        end else if ((state == RUN) && lap_edge) begin
            hold <= ~hold;
            if (!hold) snap <= q;
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) disp[i] = hold ? snap[i] : q[i];
    end
`else
    logic unused_lap;
    assign unused_lap = lap;

    always_comb begin
        for (int i = 0; i < 6; i++) disp[i] = q[i];
    end
`endif

    assign dig0 = disp[0];
    assign dig1 = disp[1];
    assign dig2 = disp[2];
    assign dig3 = disp[3];
    assign dig4 = disp[4];
    assign dig5 = disp[5];

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch at CLK_HZ=1000, TICK_HZ=100 (10 clocks per tick).
// Digits are compared packed as 24'hMMSScc; lap-hold steps follow LAP_HOLD_EN.
module tb_bcd_stopwatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop, clear, lap;
    logic [3:0] dig0, dig1, dig2, dig3, dig4, dig5;
    logic       running, wrap;

    int checks   = 0;
    int failures = 0;

    bcd_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dig4       (dig4),
        .dig5       (dig5),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the chosen buttons at a negedge; the state has acted once this returns.
    task automatic press(input logic ss, input logic cl, input logic lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        cyc(3);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] shown();
        return {dig5, dig4, dig3, dig2, dig1, dig0};
    endfunction

    initial begin
        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        cyc(3);
        chk("reset_digits",  shown(),         24'h000000);
        chk("reset_running", {23'd0, running}, 24'd0);
        chk("reset_wrap",    {23'd0, wrap},    24'd0);
        rst = 1'b0;
        cyc(2);

        // Start and run 100 clocks: ten ticks.
        press(1'b1, 1'b0, 1'b0);
        chk("start_digits",  shown(),          24'h000000);
        chk("start_running", {23'd0, running}, 24'd1);
        cyc(100);
        chk("run100_digits",  shown(),          24'h000010);
        chk("run100_running", {23'd0, running}, 24'd1);

        // Clear during RUN is ignored; pause holds; clear from PAUSE zeroes.
        press(1'b0, 1'b1, 1'b0);
        chk("clr_in_run_digits",  shown(),          24'h000010);
        chk("clr_in_run_running", {23'd0, running}, 24'd1);
        press(1'b1, 1'b0, 1'b0);
        chk("pause_digits",  shown(),          24'h000010);
        chk("pause_running", {23'd0, running}, 24'd0);
        press(1'b0, 1'b1, 1'b0);
        chk("clr_pause_digits",  shown(),          24'h000000);
        chk("clr_pause_running", {23'd0, running}, 24'd0);

        // Pause lands on the 57th RUN clock, so prescaler holds at 7.
        press(1'b1, 1'b0, 1'b0);
        cyc(54);
        press(1'b1, 1'b0, 1'b0);
        chk("p57_digits",  shown(),          24'h000005);
        chk("p57_running", {23'd0, running}, 24'd0);
        cyc(200);
        chk("p57_held", shown(), 24'h000005);
        press(1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("resume_2clk", shown(), 24'h000005);
        cyc(1);
        chk("resume_3clk", shown(), 24'h000006);

        // Start and clear together from PAUSE: clear wins.
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        chk("ss_clr_digits",  shown(),          24'h000000);
        chk("ss_clr_running", {23'd0, running}, 24'd0);

        // Preload 59:59.98 while IDLE, then two ticks through the roll-over.
        force dut.u_d0.cnt = 4'd8;
        force dut.u_d1.cnt = 4'd9;
        force dut.u_d2.cnt = 4'd9;
        force dut.u_d3.cnt = 4'd5;
        force dut.u_d4.cnt = 4'd9;
        force dut.u_d5.cnt = 4'd5;
        cyc(1);
        release dut.u_d0.cnt;
        release dut.u_d1.cnt;
        release dut.u_d2.cnt;
        release dut.u_d3.cnt;
        release dut.u_d4.cnt;
        release dut.u_d5.cnt;
        cyc(1);
        chk("preload", shown(), 24'h595998);
        press(1'b1, 1'b0, 1'b0);
        cyc(10);
        chk("tick_5999_digits", shown(),       24'h595999);
        chk("tick_5999_wrap",   {23'd0, wrap}, 24'd0);
        cyc(9);
        chk("pre_roll_wrap", {23'd0, wrap}, 24'd0);
        cyc(1);
        chk("roll_digits",  shown(),          24'h000000);
        chk("roll_wrap",    {23'd0, wrap},    24'd1);
        chk("roll_running", {23'd0, running}, 24'd1);
        cyc(1);
        chk("roll_wrap_drop", {23'd0, wrap}, 24'd0);

        // Async reset in the middle of a run at 00:12.34.
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        cyc(12340);
        chk("run_1234", shown(), 24'h001234);
        #2 rst = 1'b1;
        #1;
        chk("arst_digits",  shown(),          24'h000000);
        chk("arst_running", {23'd0, running}, 24'd0);
        chk("arst_wrap",    {23'd0, wrap},    24'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        press(1'b1, 1'b0, 1'b0);
        cyc(9);
        chk("post_rst_9clk", shown(), 24'h000000);
        cyc(1);
        chk("post_rst_10clk", shown(), 24'h000001);

        // Lap: hold shows the snapshot, release shows the live count.
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        cyc(200);
        chk("lap_before", shown(), 24'h000020);
        press(1'b0, 1'b0, 1'b1);
        chk("lap_pressed", shown(), 24'h000020);
        cyc(50);
`ifdef LAP_HOLD_EN
        chk("lap_hold_50", shown(), 24'h000020);
`else
        chk("lap_live_50", shown(), 24'h000025);
`endif
        press(1'b0, 1'b0, 1'b1);
        chk("lap_release", shown(), 24'h000025);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
